matrix_load_unit: RTL and testbench



---
 rtl/matrix_load_unit_pkg.sv | 42 ++++
 rtl/matrix_load_unit_if.sv | 42 ++++
 rtl/matrix_load_unit_counter.sv | 45 ++++
 rtl/matrix_load_unit.sv | 129 ++++++++++++
 tb/tb_matrix_load_unit.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/matrix_load_unit_pkg.sv
// Shared types and sizes for the matrix load path.
// Holds the FSM state enum, request bundle and dimension check.
package matrix_load_unit_pkg;

  localparam int FP = 32;
  localparam int M = 4;
  localparam int N = 4;
  localparam int MATRIX_REGISTERS = 8;

  localparam int AW = $clog2(MATRIX_REGISTERS);
  localparam int MW = $clog2(M + 1);
  localparam int NW = $clog2(N + 1);
  localparam int RW = $clog2(M);
  localparam int CW = $clog2(N);
  localparam int IW = (RW > CW) ? RW : CW;

  typedef enum logic [1:0] {
    LOAD_IDLE,
    LOAD_REQUEST,
    LOAD_MATRIX,
    LOAD_ERROR
  } load_state_e;

  typedef struct packed {
    logic [AW-1:0] dest_addr;
    logic [MW-1:0] m;
    logic [NW-1:0] n;
    logic          transpose;
  } load_req_t;

  // Transposed loads swap which source dimension must fit which limit.
  function automatic logic dims_ok(load_req_t r);
    logic ok;
    ok = (r.m != '0) && (r.n != '0);
    if (r.transpose)
      ok = ok && (int'(r.n) <= M) && (int'(r.m) <= N);
    else
      ok = ok && (int'(r.m) <= M) && (int'(r.n) <= N);
    return ok;
  endfunction

endpackage

// File: rtl/matrix_load_unit_if.sv
// Request, element stream and register write bundle of the loader.
// slave = loader side, master = requester / register file side.
interface matrix_load_unit_if;
  import matrix_load_unit_pkg::*;

  logic          load_req_i;
  logic          load_ready_o;
  logic [AW-1:0] dest_addr_i;
  logic [MW-1:0] m_in_i;
  logic [NW-1:0] n_in_i;
  logic          transpose_i;
  logic          elem_valid_i;
  logic          elem_ready_o;
  logic [FP-1:0] elem_data_i;
  logic          reg_wr_en_o;
  logic [AW-1:0] reg_wr_addr_o;
  logic [RW-1:0] reg_wr_row_o;
  logic [CW-1:0] reg_wr_col_o;
  logic [FP-1:0] reg_wr_data_o;
  logic          busy_o;
  logic          done_o;
  logic          error_o;

  modport slave (
    input  load_req_i, dest_addr_i, m_in_i, n_in_i,
    input  transpose_i, elem_valid_i, elem_data_i,
    output load_ready_o, elem_ready_o,
    output reg_wr_en_o, reg_wr_addr_o,
    output reg_wr_row_o, reg_wr_col_o, reg_wr_data_o,
    output busy_o, done_o, error_o
  );

  modport master (
    output load_req_i, dest_addr_i, m_in_i, n_in_i,
    output transpose_i, elem_valid_i, elem_data_i,
    input  load_ready_o, elem_ready_o,
    input  reg_wr_en_o, reg_wr_addr_o,
    input  reg_wr_row_o, reg_wr_col_o, reg_wr_data_o,
    input  busy_o, done_o, error_o
  );

endinterface

// File: rtl/matrix_load_unit_counter.sv
// matrix_index_counter: row-major row/col walker with wrap.
// Ports: clear, step, dims in; row, col, last-element flag out.
module matrix_index_counter #(
  parameter int W   = 2,
  parameter int RLW = 3,
  parameter int CLW = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clear_i,
  input  logic           step_i,
  input  logic [RLW-1:0] rows_i,
  input  logic [CLW-1:0] cols_i,
  output logic [W-1:0]   row_o,
  output logic [W-1:0]   col_o,
  output logic           last_o
);

  logic [W-1:0] row_q;
  logic [W-1:0] col_q;
  logic         col_last;
  logic         row_last;

  assign col_last = CLW'(col_q) == cols_i - CLW'(1);
  assign row_last = RLW'(row_q) == rows_i - RLW'(1);

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      row_q <= '0;
      col_q <= '0;
    end else if (step_i) begin
      if (col_last) begin
        col_q <= '0;
        row_q <= row_q + W'(1);
      end else begin
        col_q <= col_q + W'(1);
      end
    end
  end

  assign row_o  = row_q;
  assign col_o  = col_q;
  assign last_o = row_last & col_last;

endmodule

// File: rtl/matrix_load_unit.sv
// Streams an m x n matrix into the register file, optionally transposed.
// Ports: clk, rst, lb (request, element stream, write port, status).
module matrix_load_unit
  import matrix_load_unit_pkg::*;
(
  input logic               clk,
  input logic               rst,
  matrix_load_unit_if.slave lb
);

  load_state_e   state_q;
  load_req_t     req_q;
  logic          load_ready_q;
  logic          elem_ready_q;
  logic          busy_q;
  logic          done_q;
  logic          error_q;
  logic          wr_en_q;
  logic [AW-1:0] wr_addr_q;
  logic [RW-1:0] wr_row_q;
  logic [CW-1:0] wr_col_q;
  logic [FP-1:0] wr_data_q;

  logic          hs;
  logic [IW-1:0] r_idx;
  logic [IW-1:0] c_idx;
  logic          last;

  // elem_ready_q is only ever set in LOAD_MATRIX.
  assign hs = lb.elem_valid_i & elem_ready_q;

  matrix_index_counter #(
    .W  (IW),
    .RLW(MW),
    .CLW(NW)
  ) u_idx (
    .clk    (clk),
    .rst    (rst),
    .clear_i(state_q == LOAD_REQUEST),
    .step_i (hs),
    .rows_i (req_q.m),
    .cols_i (req_q.n),
    .row_o  (r_idx),
    .col_o  (c_idx),
    .last_o (last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= LOAD_IDLE;
      req_q        <= '0;
      load_ready_q <= 1'b1;
      elem_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_row_q     <= '0;
      wr_col_q     <= '0;
      wr_data_q    <= '0;
    end else begin
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      unique case (state_q)
        LOAD_IDLE: begin
          if (lb.load_req_i) begin
            req_q.dest_addr <= lb.dest_addr_i;
            req_q.m         <= lb.m_in_i;
            req_q.n         <= lb.n_in_i;
            req_q.transpose <= lb.transpose_i;
            state_q         <= LOAD_REQUEST;
            load_ready_q    <= 1'b0;
            busy_q          <= 1'b1;
          end
        end
        LOAD_REQUEST: begin
          if (dims_ok(req_q)) begin
            state_q      <= LOAD_MATRIX;
            elem_ready_q <= 1'b1;
          end else begin
            state_q <= LOAD_ERROR;
            error_q <= 1'b1;
          end
        end
        LOAD_MATRIX: begin
          if (hs) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= req_q.dest_addr;
            wr_data_q <= lb.elem_data_i;
            if (req_q.transpose) begin
              wr_row_q <= RW'(c_idx);
              wr_col_q <= CW'(r_idx);
            end else begin
              wr_row_q <= RW'(r_idx);
              wr_col_q <= CW'(c_idx);
            end
            if (last) begin
              state_q      <= LOAD_IDLE;
              done_q       <= 1'b1;
              elem_ready_q <= 1'b0;
              load_ready_q <= 1'b1;
              busy_q       <= 1'b0;
            end
          end
        end
        LOAD_ERROR: begin
          state_q      <= LOAD_IDLE;
          load_ready_q <= 1'b1;
          busy_q       <= 1'b0;
        end
        default: state_q <= LOAD_IDLE;
      endcase
    end
  end

  assign lb.load_ready_o  = load_ready_q;
  assign lb.elem_ready_o  = elem_ready_q;
  assign lb.busy_o        = busy_q;
  assign lb.done_o        = done_q;
  assign lb.error_o       = error_q;
  assign lb.reg_wr_en_o   = wr_en_q;
  assign lb.reg_wr_addr_o = wr_addr_q;
  assign lb.reg_wr_row_o  = wr_row_q;
  assign lb.reg_wr_col_o  = wr_col_q;
  assign lb.reg_wr_data_o = wr_data_q;

endmodule

// File: tb/tb_matrix_load_unit.sv
// Directed bench for matrix_load_unit.
// Table of load requests plus reset and back-to-back sequences.
module tb_matrix_load_unit;
  import matrix_load_unit_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  matrix_load_unit_if bus();

  matrix_load_unit dut (
    .clk(clk),
    .rst(rst),
    .lb (bus)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [2:0]  addr;
    logic [1:0]  row;
    logic [1:0]  col;
    logic [31:0] data;
  } wr_t;

  wr_t  wq[$];
  int   wcyc[$];
  int   ncyc = 0;
  int   req_n = 0;
  int   done_cnt = 0;
  int   done_n = 0;
  int   err_cnt = 0;
  int   err_n = 0;
  int   busy_low_n = 0;
  logic busy_prev = 1'b0;

  always @(negedge clk) begin
    ncyc++;
    if (bus.load_req_i && bus.load_ready_o) req_n = ncyc;
    if (bus.reg_wr_en_o) begin
      wq.push_back({bus.reg_wr_addr_o, bus.reg_wr_row_o,
                    bus.reg_wr_col_o, bus.reg_wr_data_o});
      wcyc.push_back(ncyc);
    end
    if (bus.done_o) begin
      done_cnt++;
      done_n = ncyc;
    end
    if (bus.error_o) begin
      err_cnt++;
      err_n = ncyc;
    end
    if (busy_prev && !bus.busy_o) busy_low_n = ncyc;
    busy_prev = bus.busy_o;
  end

  function automatic logic [31:0] fpk(input int k);
    case (k)
      1: return 32'h3F80_0000;
      2: return 32'h4000_0000;
      3: return 32'h4040_0000;
      4: return 32'h4080_0000;
      5: return 32'h40A0_0000;
      6: return 32'h40C0_0000;
      7: return 32'h40E0_0000;
      8: return 32'h4100_0000;
      9: return 32'h4110_0000;
      10: return 32'h4120_0000;
      11: return 32'h4130_0000;
      12: return 32'h4140_0000;
      13: return 32'h4150_0000;
      14: return 32'h4160_0000;
      15: return 32'h4170_0000;
      16: return 32'h4180_0000;
      default: return 32'h0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wq.delete();
    wcyc.delete();
    done_cnt = 0;
    err_cnt = 0;
    done_n = 0;
    err_n = 0;
    busy_low_n = 0;
  endtask

  task automatic start_req(input logic [2:0] d, input int m,
                           input int n, input bit tr);
    int b = 0;
    while (!bus.load_ready_o && b < 20) begin
      tick();
      b++;
    end
    if (b >= 20) chk("req_ready_timeout", 64'(b), 64'(0));
    bus.dest_addr_i = d;
    bus.m_in_i      = 3'(m);
    bus.n_in_i      = 3'(n);
    bus.transpose_i = tr;
    bus.load_req_i  = 1'b1;
    tick();
    bus.load_req_i  = 1'b0;
  endtask

  task automatic stream(input int total, input bit gaps, input int base);
    bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int k = 0;
    int i = 0;
    bit hs;
    while (k < total && i < 300) begin
      bus.elem_valid_i = gaps ? pat[i % 4] : 1'b1;
      bus.elem_data_i  = fpk(base + k + 1);
      hs = bus.elem_valid_i && bus.elem_ready_o;
      tick();
      if (hs) k++;
      i++;
    end
    bus.elem_valid_i = 1'b0;
    if (k != total) chk("stream_timeout", 64'(k), 64'(total));
  endtask

  typedef struct {
    logic [2:0] dest;
    int         m;
    int         n;
    bit         tr;
    bit         gaps;
    bit         err;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{3'd2, 3, 3, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{3'd5, 2, 3, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{3'd1, 5, 2, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{3'd1, 0, 3, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{3'd3, 3, 0, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{3'd4, 2, 5, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{3'd4, 4, 2, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{3'd6, 2, 5, 1'b1, 1'b0, 1'b1};
    vecs[8] = '{3'd7, 4, 4, 1'b0, 1'b1, 1'b0};

    rst = 1'b1;
    bus.load_req_i   = 1'b0;
    bus.dest_addr_i  = '0;
    bus.m_in_i       = '0;
    bus.n_in_i       = '0;
    bus.transpose_i  = 1'b0;
    bus.elem_valid_i = 1'b0;
    bus.elem_data_i  = '0;
    repeat (3) tick();
    chk("rst_load_ready", 64'(bus.load_ready_o), 64'(1));
    chk("rst_elem_ready", 64'(bus.elem_ready_o), 64'(0));
    chk("rst_busy", 64'(bus.busy_o), 64'(0));
    chk("rst_done", 64'(bus.done_o), 64'(0));
    chk("rst_error", 64'(bus.error_o), 64'(0));
    chk("rst_wr_en", 64'(bus.reg_wr_en_o), 64'(0));
    chk("rst_wr_data", 64'(bus.reg_wr_data_o), 64'(0));
    rst = 1'b0;
    tick();

    for (int v = 0; v < 9; v++) begin
      clear_log();
      start_req(vecs[v].dest, vecs[v].m, vecs[v].n, vecs[v].tr);
      if (!vecs[v].err)
        stream(vecs[v].m * vecs[v].n, vecs[v].gaps, 0);
      repeat (5) tick();
      if (vecs[v].err) begin
        chk("err_count", 64'(err_cnt), 64'(1));
        chk("err_cycle", 64'(err_n), 64'(req_n + 2));
        chk("err_busy_low", 64'(busy_low_n), 64'(req_n + 3));
        chk("err_no_writes", 64'(wq.size()), 64'(0));
        chk("err_no_done", 64'(done_cnt), 64'(0));
      end else begin
        int tot;
        int last_c;
        tot = vecs[v].m * vecs[v].n;
        last_c = 0;
        chk("wr_count", 64'(wq.size()), 64'(tot));
        chk("no_error", 64'(err_cnt), 64'(0));
        for (int k = 0; k < tot && k < wq.size(); k++) begin
          wr_t e;
          int r;
          int c;
          int ec;
          r = k / vecs[v].n;
          c = k % vecs[v].n;
          e.addr = vecs[v].dest;
          e.row  = vecs[v].tr ? 2'(c) : 2'(r);
          e.col  = vecs[v].tr ? 2'(r) : 2'(c);
          e.data = fpk(k + 1);
          if (vecs[v].gaps)
            ec = req_n + 5 + 4 * (k / 2) + (k % 2);
          else
            ec = req_n + 3 + k;
          chk($sformatf("wr%0d_elem%0d", v, k), 64'(wq[k]), 64'(e));
          chk($sformatf("wr%0d_cyc%0d", v, k), 64'(wcyc[k]), 64'(ec));
          last_c = ec;
        end
        chk("done_count", 64'(done_cnt), 64'(1));
        chk("done_cycle", 64'(done_n), 64'(last_c));
      end
    end

    clear_log();
    start_req(3'd3, 3, 3, 1'b0);
    stream(4, 1'b0, 0);
    rst = 1'b1;
    tick();
    chk("mid_rst_wr_en", 64'(bus.reg_wr_en_o), 64'(0));
    chk("mid_rst_done", 64'(bus.done_o), 64'(0));
    chk("mid_rst_error", 64'(bus.error_o), 64'(0));
    chk("mid_rst_busy", 64'(bus.busy_o), 64'(0));
    chk("mid_rst_elem_ready", 64'(bus.elem_ready_o), 64'(0));
    chk("mid_rst_load_ready", 64'(bus.load_ready_o), 64'(1));
    rst = 1'b0;
    repeat (3) tick();
    chk("mid_rst_writes", 64'(wq.size()), 64'(4));
    chk("mid_rst_no_done", 64'(done_cnt), 64'(0));
    clear_log();
    start_req(3'd0, 2, 2, 1'b0);
    stream(4, 1'b0, 0);
    repeat (3) tick();
    chk("post_rst_writes", 64'(wq.size()), 64'(4));
    chk("post_rst_done", 64'(done_cnt), 64'(1));
    if (wq.size() == 4)
      chk("post_rst_last", 64'(wq[3]),
          64'({3'd0, 2'd1, 2'd1, fpk(4)}));

    clear_log();
    start_req(3'd1, 2, 2, 1'b0);
    stream(4, 1'b0, 0);
    chk("b2b_done_now", 64'(bus.done_o), 64'(1));
    chk("b2b_ready_now", 64'(bus.load_ready_o), 64'(1));
    start_req(3'd6, 2, 2, 1'b0);
    chk("b2b_accept_cycle", 64'(req_n), 64'(done_n));
    stream(4, 1'b0, 4);
    repeat (4) tick();
    chk("b2b_writes", 64'(wq.size()), 64'(8));
    chk("b2b_done_count", 64'(done_cnt), 64'(2));
    if (wq.size() == 8) begin
      chk("b2b_a_first", 64'(wq[0]),
          64'({3'd1, 2'd0, 2'd0, fpk(1)}));
      chk("b2b_b_first", 64'(wq[4]),
          64'({3'd6, 2'd0, 2'd0, fpk(5)}));
      chk("b2b_b_last", 64'(wq[7]),
          64'({3'd6, 2'd1, 2'd1, fpk(8)}));
      chk("b2b_b_cycle", 64'(wcyc[4]), 64'(req_n + 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
